// File: rtl/ahbl_sram_slave_p.sv
// ahbl_sram_slave_p: AHB-Lite SRAM slave of 2^ADDR_WIDTH bytes (32-bit words),
// with configurable wait states, two-cycle ERROR responses and RAW forwarding.
// Ports: HCLK, HRESETn (async, active low); inputs HSEL, HADDR, HTRANS, HREADY,
// HSIZE, HWRITE, HWDATA; outputs HREADYOUT, HRESP, HRDATA.
module ahbl_sram_slave_p #(
    parameter int ADDR_WIDTH      = 13,
    parameter int WAIT_STATES     = 0,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic          wr_pend_q, wr_pend_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    strb_q, strb_d;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          illegal;
    logic          commit;
    logic [3:0]    strb;
    logic [IW-1:0] idx;
    logic [31:0]   wmask;
    logic [31:0]   rd_word;
    logic [31:0]   fwd_word;
    logic          unused_ok;

    assign accept    = HSEL & HTRANS[1] & HREADY;
    assign idx       = HADDR[ADDR_WIDTH-1:2];
    assign unused_ok = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};

    // Lane strobe; with misalign errors off, the low bits just select
    // the aligned half/word.
    always_comb begin
        illegal = 1'b0;
        strb    = 4'b1111;
        unique case (HSIZE)
            3'd0: strb = 4'b0001 << HADDR[1:0];
            3'd1: begin
                strb    = HADDR[1] ? 4'b1100 : 4'b0011;
                illegal = ERR_ON_MISALIGN & HADDR[0];
            end
            3'd2: illegal = ERR_ON_MISALIGN & (HADDR[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // A pending write's data phase ends once the FSM is back in IDLE.
    assign commit  = wr_pend_q & (state_q == S_IDLE);
    assign wmask   = {{8{strb_q[3]}}, {8{strb_q[2]}},
                      {8{strb_q[1]}}, {8{strb_q[0]}}};
    assign rd_word = mem[idx];

    // A read accepted on the commit edge of a write to the same word
    // must already see the freshly written lanes.
    assign fwd_word = (commit && (idx_q == idx)) ?
                      ((rd_word & ~wmask) | (HWDATA & wmask)) : rd_word;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        wr_pend_d   = wr_pend_q;
        idx_d       = idx_q;
        strb_d      = strb_q;
        if (commit) begin
            wr_pend_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE, S_ERR2: begin
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (accept) begin
                    if (illegal) begin
                        state_d     = S_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = 1'b1;
                    end else begin
                        wr_pend_d = HWRITE;
                        idx_d     = idx;
                        strb_d    = strb;
                        if (!HWRITE) begin
                            hrdata_d = fwd_word;
                        end
                        if (WS != 4'd0) begin
                            state_d     = S_WAIT;
                            cnt_d       = WS;
                            hreadyout_d = 1'b0;
                        end
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = S_IDLE;
                    hreadyout_d = 1'b1;
                end
            end
            S_ERR1: begin
                state_d     = S_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'd0;
            wr_pend_q   <= 1'b0;
            idx_q       <= '0;
            strb_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            wr_pend_q   <= wr_pend_d;
            idx_q       <= idx_d;
            strb_q      <= strb_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule
